// File: rtl/vga_coord_gen_pkg.sv
// Shared VGA timing defaults (1280x1024 @ 60 Hz) plus small helpers used by
// the coordinate generator and anything else that decodes screen positions.
package vga_coord_gen_pkg;

    typedef logic [11:0] coord_t;

    localparam int DEF_H_ACTIVE = 1280;
    localparam int DEF_H_FP     = 48;
    localparam int DEF_H_SYNC   = 112;
    localparam int DEF_H_BP     = 248;

    localparam int DEF_V_ACTIVE = 1024;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 38;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_FIRST = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_LAST  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC - 1;
    localparam int DEF_VS_FIRST = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_LAST  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC - 1;

    // Inclusive window test on a 12-bit coordinate.
    function automatic logic inWindow(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One screen axis: a modulo-MODULUS up-counter with an increment enable.
// nextCount is exposed so the parent can register decoded flags in lockstep
// with the coordinate itself.
module vga_axis_counter
    import vga_coord_gen_pkg::*;
#(
    parameter int MODULUS = DEF_H_TOTAL
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    output coord_t count,
    output coord_t nextCount,
    output logic   wrap
);

    localparam coord_t LAST = coord_t'(MODULUS - 1);

    // Next value: hold when not incrementing, otherwise step and wrap at LAST.
    always_comb begin
        wrap      = 1'b0;
        nextCount = count;
        if (inc) begin
            if (count == LAST) begin
                wrap      = 1'b1;
                nextCount = '0;
            end else begin
                nextCount = count + coord_t'(1);
            end
        end
    end

    // Coordinate register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

endmodule

// File: rtl/vga_coord_gen.sv
// VGA raster coordinate generator: pixel/line counters plus registered sync,
// visible-area and frame-start flags aligned to the presented coordinate.
module vga_coord_gen
    import vga_coord_gen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        CLK_VGA,
    input  logic        RST_N,
    input  logic        EN,
    output logic [11:0] VGA_horzCoord,
    output logic [11:0] VGA_vertCoord,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_active,
    output logic        frame_start
);

    localparam int     H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam coord_t H_VIS    = coord_t'(H_ACTIVE);
    localparam coord_t V_VIS    = coord_t'(V_ACTIVE);

    coord_t horzNext;
    coord_t vertNext;
    logic   horzWrap;
    logic   vertWrap;
    logic   vertInc;

    assign vertInc = EN & horzWrap;

    vga_axis_counter #(.MODULUS(H_TOTAL)) uHorz (
        .clk       (CLK_VGA),
        .rst_n     (RST_N),
        .inc       (EN),
        .count     (VGA_horzCoord),
        .nextCount (horzNext),
        .wrap      (horzWrap)
    );

    vga_axis_counter #(.MODULUS(V_TOTAL)) uVert (
        .clk       (CLK_VGA),
        .rst_n     (RST_N),
        .inc       (vertInc),
        .count     (VGA_vertCoord),
        .nextCount (vertNext),
        .wrap      (vertWrap)
    );

    // Flags are decoded from the counters' next values so that, once
    // registered, they line up with the coordinate presented in that cycle.
    // The reset coordinate (0,0) is visible, hence VGA_active resets high.
    always_ff @(posedge CLK_VGA or negedge RST_N) begin
        if (!RST_N) begin
            VGA_HS      <= 1'b0;
            VGA_VS      <= 1'b0;
            VGA_active  <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= EN & horzWrap & vertWrap;
            if (EN) begin
                VGA_HS     <= inWindow(horzNext, HS_FIRST, HS_LAST);
                VGA_VS     <= inWindow(vertNext, VS_FIRST, VS_LAST);
                VGA_active <= (horzNext < H_VIS) && (vertNext < V_VIS);
            end
        end
    end

endmodule
